lifo_stack: RTL and testbench

- Synchronous last-in-first-out stack of DEPTH entries, each WIDTH bits wide.
- Single-port interface: one direction bit (RW) selects push or pop, gated by EN.
- Registered read data plus combinational EMPTY/FULL status.
- Used as a small scratch stack in control datapaths. Single clock domain.

---
 rtl/lifo_pkg.sv | 16 +
 rtl/lifo_mem.sv | 44 ++++
 rtl/lifo_stack.sv | 110 +++++++++++
 tb/tb_lifo_stack.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/lifo_pkg.sv
// lifo_pkg: shared constants and helpers for the lifo_stack slice.
// Default geometry, stack-pointer width helper and RW direction encodings.
package lifo_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int DEPTH_DEF = 8;

    localparam logic RW_PUSH = 1'b0;
    localparam logic RW_POP  = 1'b1;

    // Stack pointer counts 0..DEPTH inclusive, so it needs one bit above the address width.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : lifo_pkg

// File: rtl/lifo_mem.sv
// lifo_mem: DEPTH x WIDTH register array for lifo_stack.
// One synchronous write port, one registered read port, asynchronous clear
// of both the array and the read register.
module lifo_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Storage array: cleared on reset, written at the current top on push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read register: captures the popped entry; holds its value when no pop occurs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= {WIDTH{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule : lifo_mem

// File: rtl/lifo_stack.sv
// lifo_stack: synchronous LIFO of DEPTH entries x WIDTH bits.
// Single-port push/pop selected by RW, gated by EN; registered pop data and
// combinational EMPTY/FULL derived from the stack pointer.
// Optional feature macro LIFO_ERR_EN adds sticky OVF/UNF error outputs.
module lifo_stack
    import lifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             EN,
    input  logic             RW,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    output logic             EMPTY,
    output logic             FULL
`ifdef LIFO_ERR_EN
    ,
    output logic             OVF,
    output logic             UNF
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    localparam logic [PW-1:0] SP_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] SP_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] SP_FULL = PW'(DEPTH);
    localparam logic [AW-1:0] AD_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [PW-1:0] sp_r;
    logic          empty_s;
    logic          full_s;
    logic          push_req_s;
    logic          pop_req_s;
    logic          push_s;
    logic          pop_s;
    logic [AW-1:0] waddr_s;
    logic [AW-1:0] raddr_s;

    // Decode requests and qualify them against the saturation flags.
    always_comb begin
        empty_s    = (sp_r == SP_ZERO);
        full_s     = (sp_r == SP_FULL);
        push_req_s = EN && (RW == RW_PUSH);
        pop_req_s  = EN && (RW == RW_POP);
        push_s     = push_req_s && !full_s;
        pop_s      = pop_req_s && !empty_s;
        // At sp == DEPTH the low bits wrap to 0, but push is blocked there and
        // 0 - 1 lands on DEPTH-1, which is the correct top for a pop.
        waddr_s    = sp_r[AW-1:0];
        raddr_s    = sp_r[AW-1:0] - AD_ONE;
    end

    // Stack pointer: increments on accepted push, decrements on accepted pop.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sp_r <= SP_ZERO;
        end else if (push_s) begin
            sp_r <= sp_r + SP_ONE;
        end else if (pop_s) begin
            sp_r <= sp_r - SP_ONE;
        end
    end

    lifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (Clk),
        .rst   (Rst),
        .we    (push_s),
        .waddr (waddr_s),
        .wdata (dataIn),
        .re    (pop_s),
        .raddr (raddr_s),
        .rdata (dataOut)
    );

    assign EMPTY = empty_s;
    assign FULL  = full_s;

`ifdef LIFO_ERR_EN
    logic ovf_r;
    logic unf_r;

    // Sticky error flags: set by a rejected push/pop, cleared only by reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            if (push_req_s && full_s) begin
                ovf_r <= 1'b1;
            end
            if (pop_req_s && empty_s) begin
                unf_r <= 1'b1;
            end
        end
    end

    assign OVF = ovf_r;
    assign UNF = unf_r;
`endif

endmodule : lifo_stack

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed scoreboard bench for lifo_stack (WIDTH=4, DEPTH=8).
// Stimulus pushes the expected post-edge {dataOut, EMPTY, FULL} into a queue;
// a monitor on the falling edge pops and compares.
module tb_lifo_stack;

    logic       clk;
    logic       rst;
    logic       en;
    logic       rw;
    logic [3:0] din;
    logic [3:0] dout;
    logic       empty;
    logic       full;
`ifdef LIFO_ERR_EN
    logic       ovf;
    logic       unf;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] dout;
        logic       empty;
        logic       full;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    lifo_stack #(.WIDTH(4), .DEPTH(8)) dut (
        .Clk     (clk),
        .Rst     (rst),
        .EN      (en),
        .RW      (rw),
        .dataIn  (din),
        .dataOut (dout),
        .EMPTY   (empty),
        .FULL    (full)
`ifdef LIFO_ERR_EN
        ,
        .OVF     (ovf),
        .UNF     (unf)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got dout/empty/full=%h/%b/%b want %h/%b/%b",
                     name, act[5:2], act[1], act[0], req[5:2], req[1], req[0]);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, req);
        end
    endtask

    // Drive one operation between edges and queue its expected post-edge result.
    task automatic step(input logic r, input logic e, input logic w, input logic [3:0] d,
                        input logic [3:0] xd, input logic xe, input logic xf, input string name);
        exp_t x;
        @(negedge clk);
        #1;
        rst = r; en = e; rw = w; din = d;
        x.dout = xd; x.empty = xe; x.full = xf; x.name = name;
        exp_q.push_back(x);
    endtask

    // Monitor: each falling edge, compare outputs against the oldest expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check(x.name, {dout, empty, full}, {x.dout, x.empty, x.full});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] v;
        rst = 1'b1; en = 1'b1; rw = 1'b0; din = 4'h5;
        #1;
        check("reset_async", {dout, empty, full}, {4'h0, 1'b1, 1'b0});

        // Reset held with EN=1 for two edges.
        step(1'b1, 1'b1, 1'b0, 4'h5, 4'h0, 1'b1, 1'b0, "reset_hold0");
        step(1'b1, 1'b1, 1'b0, 4'h5, 4'h0, 1'b1, 1'b0, "reset_hold1");

        // Push 0,2,4,6 then pop four times.
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "push0");
        step(1'b0, 1'b1, 1'b0, 4'h2, 4'h0, 1'b0, 1'b0, "push2");
        step(1'b0, 1'b1, 1'b0, 4'h4, 4'h0, 1'b0, 1'b0, "push4");
        step(1'b0, 1'b1, 1'b0, 4'h6, 4'h0, 1'b0, 1'b0, "push6");
        step(1'b0, 1'b1, 1'b1, 4'h9, 4'h6, 1'b0, 1'b0, "pop6");
        step(1'b0, 1'b1, 1'b1, 4'h9, 4'h4, 1'b0, 1'b0, "pop4");
        step(1'b0, 1'b1, 1'b1, 4'h9, 4'h2, 1'b0, 1'b0, "pop2");
        step(1'b0, 1'b1, 1'b1, 4'h9, 4'h0, 1'b1, 1'b0, "pop0");

        // Underflow: pops on an empty stack are ignored.
        step(1'b0, 1'b1, 1'b1, 4'h9, 4'h0, 1'b1, 1'b0, "underflow0");
        step(1'b0, 1'b1, 1'b1, 4'h9, 4'h0, 1'b1, 1'b0, "underflow1");

        // Overflow: fill with 1..8, then a rejected push of F.
        for (int i = 1; i <= 8; i++) begin
            v = 4'(i);
            step(1'b0, 1'b1, 1'b0, v, 4'h0, 1'b0, (i == 8), "push_fill");
`ifdef LIFO_ERR_EN
            if (i == 1) check_bit("unf_sticky", unf, 1'b1);
`endif
        end
        step(1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 1'b1, "push_full_ignored");
        for (int i = 8; i >= 1; i--) begin
            v = 4'(i);
            step(1'b0, 1'b1, 1'b1, 4'h0, v, (i == 1), 1'b0, "pop_drain");
`ifdef LIFO_ERR_EN
            if (i == 8) check_bit("ovf_sticky", ovf, 1'b1);
`endif
        end

        // EN gating: one entry, then five idle cycles with toggling inputs.
        step(1'b0, 1'b1, 1'b0, 4'h3, 4'h1, 1'b0, 1'b0, "push3");
        for (int i = 0; i < 5; i++) begin
            v = 4'(i * 3 + 5);
            step(1'b0, 1'b0, i[0], v, 4'h1, 1'b0, 1'b0, "en_off_hold");
        end
        step(1'b0, 1'b1, 1'b1, 4'h0, 4'h3, 1'b1, 1'b0, "pop3_after_hold");

        // Mid-operation reset.
        step(1'b0, 1'b1, 1'b0, 4'hA, 4'h3, 1'b0, 1'b0, "pushA");
        step(1'b0, 1'b1, 1'b0, 4'hB, 4'h3, 1'b0, 1'b0, "pushB");
        step(1'b0, 1'b1, 1'b1, 4'h0, 4'hB, 1'b0, 1'b0, "popB");
        @(negedge clk);
        #1;
        rst = 1'b1; en = 1'b0;
        #2;
        check("mid_reset_async", {dout, empty, full}, {4'h0, 1'b1, 1'b0});
`ifdef LIFO_ERR_EN
        check_bit("ovf_cleared", ovf, 1'b0);
        check_bit("unf_cleared", unf, 1'b0);
`endif
        #8;
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, "pop_after_reset");
        step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, "idle_final");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_lifo_stack
